// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : opcodes, FSM state encoding and instruction field helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  function automatic logic [3:0] f_op(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] ir);
    return ir[11:8];
  endfunction

  function automatic logic [3:0] f_rs1(input logic [15:0] ir);
    return ir[7:4];
  endfunction

  function automatic logic [3:0] f_rs2(input logic [15:0] ir);
    return ir[3:0];
  endfunction

  function automatic logic [7:0] f_imm8(input logic [15:0] ir);
    return ir[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// cpu_regfile : two async read ports, one sync write port, r0 hardwired to 0
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_regfile #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        i_raddr_a,
  input  logic [3:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [3:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  // Only r1..REG_COUNT-1 exist; r0 and out-of-range indices read as zero.
  logic [DATA_W-1:0] r_regs [1:REG_COUNT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (i_waddr == 4'(i)) r_regs[i] <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (i_raddr_a == 4'(i)) o_rdata_a = r_regs[i];
      if (i_raddr_b == 4'(i)) o_rdata_b = r_regs[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_cpu.sv
// ============================================================================
// multicycle_cpu : FSM-sequenced 16-bit-ISA core on a single req/ready bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                REG_COUNT = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic [DATA_W-1:0] output_reg,
  output logic              halted
);

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_out;
  logic              r_halted;

  logic [3:0]        w_op, w_rd, w_rs1, w_rs2, w_rb_idx;
  logic [7:0]        w_imm8;
  logic [DATA_W-1:0] w_rdata_a, w_rdata_b, w_alu, w_wdata;
  logic [ADDR_W-1:0] w_addr;
  logic              w_req, w_we, w_rf_we;

  assign w_op     = f_op(r_ir);
  assign w_rd     = f_rd(r_ir);
  assign w_rs1    = f_rs1(r_ir);
  assign w_rs2    = f_rs2(r_ir);
  assign w_imm8   = f_imm8(r_ir);
  assign w_rb_idx = (w_op == OP_BZ) ? w_rd : w_rs2;

  cpu_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_raddr_a (w_rs1),
    .i_raddr_b (w_rb_idx),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .i_we      (w_rf_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_alu)
  );

  // Register reads stay stable from EXEC through WB, so the ALU result is
  // simply evaluated again in WB rather than being stored.
  always_comb begin
    case (w_op)
      OP_ADD:  w_alu = w_rdata_a + w_rdata_b;
      OP_SUB:  w_alu = w_rdata_a - w_rdata_b;
      OP_AND:  w_alu = w_rdata_a & w_rdata_b;
      OP_OR:   w_alu = w_rdata_a | w_rdata_b;
      OP_XOR:  w_alu = w_rdata_a ^ w_rdata_b;
      OP_LDI:  w_alu = {{(DATA_W-8){w_imm8[7]}}, w_imm8};
      OP_LD:   w_alu = r_mdr;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    w_rf_we      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (bus_ready) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_OUT: w_next_state = S_WB;
          OP_LD, OP_ST:   w_next_state = S_MEM;
          OP_HALT:        w_next_state = S_HALTED;
          OP_NOP, OP_BZ:  w_next_state = S_FETCH;
          default:        w_next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_req   = 1'b1;
        w_we    = (w_op == OP_ST);
        w_addr  = ADDR_W'(w_rdata_a);
        w_wdata = w_rdata_b;
        if (bus_ready) w_next_state = S_WB;
      end
      S_WB: begin
        w_rf_we      = (w_op != OP_OUT) && (w_op != OP_ST);
        w_next_state = S_FETCH;
      end
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_out    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_FETCH: begin
          if (bus_ready) begin
            r_ir <= bus_rdata[15:0];
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
        S_EXEC: begin
          // r_pc already points past the BZ, so the offset is relative to BZ+1.
          if (w_op == OP_BZ && w_rdata_b == '0)
            r_pc <= r_pc + {{(ADDR_W-8){w_imm8[7]}}, w_imm8};
          if (w_op == OP_HALT) r_halted <= 1'b1;
        end
        S_MEM: begin
          if (bus_ready && w_op == OP_LD) r_mdr <= bus_rdata;
        end
        S_WB: begin
          if (w_op == OP_OUT) r_out <= w_rdata_a;
        end
        default: ;
      endcase
    end
  end

  // Reset forces the bus idle immediately, dropping any pending transfer.
  assign bus_req    = w_req && !reset;
  assign bus_we     = w_we && bus_req;
  assign bus_addr   = bus_req ? w_addr : '0;
  assign bus_wdata  = bus_req ? w_wdata : '0;
  assign output_reg = r_out;
  assign halted     = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
// ============================================================================
// tb_multicycle_cpu : ISA-level reference model checking every bus transfer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req, bus_we, bus_ready;
  logic [15:0] bus_addr, bus_wdata, bus_rdata, output_reg;
  logic        halted;

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;
  assign bus_rdata = mem[bus_addr];

  multicycle_cpu dut (
    .clk        (clk),
    .reset      (reset),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready),
    .output_reg (output_reg),
    .halted     (halted)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural model
  logic [15:0] m_r [16];
  logic [15:0] m_pc, m_out;
  bit          m_halted, m_halt_pend;
  bit          m_data_pend, m_dwe;
  logic [15:0] m_daddr, m_dwdata;
  logic [3:0]  m_drd;
  bit          m_have_prev;
  logic [3:0]  m_prev_op;
  int          m_gap, m_stalls, m_fetches;

  // Bus protocol tracking
  bit          p_wait, p_we;
  logic [15:0] p_addr, p_wdata;
  int          req_age;
  int          ready_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rr(input logic [3:0] idx);
    return (idx == 4'd0) ? 16'h0000 : m_r[idx];
  endfunction

  task automatic wr(input logic [3:0] idx, input logic [15:0] v);
    if (idx != 4'd0) m_r[idx] = v;
  endtask

  function automatic int lat(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA: return 3;
      4'h7, 4'h8: return 4;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    m_pc = 16'h0; m_out = 16'h0;
    m_halted = 0; m_halt_pend = 0; m_data_pend = 0;
    m_have_prev = 0; m_gap = 0; m_stalls = 0; m_fetches = 0;
  endtask

  task automatic exec(input logic [15:0] inst);
    logic [3:0]  op, rd, rs1, rs2;
    logic [15:0] simm;
    op = inst[15:12]; rd = inst[11:8]; rs1 = inst[7:4]; rs2 = inst[3:0];
    simm = {{8{inst[7]}}, inst[7:0]};
    m_pc = m_pc + 16'd1;
    case (op)
      4'h1: wr(rd, rr(rs1) + rr(rs2));
      4'h2: wr(rd, rr(rs1) - rr(rs2));
      4'h3: wr(rd, rr(rs1) & rr(rs2));
      4'h4: wr(rd, rr(rs1) | rr(rs2));
      4'h5: wr(rd, rr(rs1) ^ rr(rs2));
      4'h6: wr(rd, simm);
      4'h7: begin m_data_pend = 1; m_dwe = 0; m_daddr = rr(rs1); m_drd = rd; end
      4'h8: begin m_data_pend = 1; m_dwe = 1; m_daddr = rr(rs1); m_dwdata = rr(rs2); end
      4'h9: if (rr(rd) == 16'h0) m_pc = m_pc + simm;
      4'hA: m_out = rr(rs1);
      4'hF: m_halt_pend = 1;
      default: ;
    endcase
  endtask

  // One clock: drive inputs at negedge, sample #1 later, then advance the
  // model to what the following rising edge must produce.
  task automatic tick(input bit rst_in);
    logic [15:0] inst;
    @(negedge clk);
    reset = rst_in;
    case (ready_mode)
      0:       bus_ready = 1'b1;
      1:       bus_ready = (req_age >= 4);
      default: bus_ready = ($urandom_range(0, 9) < 7);
    endcase
    #1;
    check("halted", halted, m_halted);
    if (m_halted) begin
      check("halted_out", output_reg, m_out);
      check("halted_req", bus_req, 1'b0);
    end
    if (reset) check("reset_req", bus_req, 1'b0);
    if (!bus_req) check("idle_we", bus_we, 1'b0);
    if (p_wait && !reset) begin
      check("hold_req", bus_req, 1'b1);
      check("hold_addr", bus_addr, p_addr);
      check("hold_we", bus_we, p_we);
      if (p_we) check("hold_wdata", bus_wdata, p_wdata);
    end

    if (reset) begin
      model_reset();
    end else begin
      m_gap++;
      if (m_halt_pend) begin m_halted = 1; m_halt_pend = 0; end
      if (bus_req && !bus_ready) m_stalls++;
      if (bus_req && bus_ready) begin
        if (m_data_pend) begin
          check("data_addr", bus_addr, m_daddr);
          check("data_we", bus_we, m_dwe);
          if (m_dwe) begin
            check("data_wdata", bus_wdata, m_dwdata);
            mem[bus_addr] = bus_wdata;
          end else begin
            wr(m_drd, mem[m_daddr]);
          end
          m_data_pend = 0;
        end else begin
          check("fetch_addr", bus_addr, m_pc);
          check("fetch_we", bus_we, 1'b0);
          check("output_reg", output_reg, m_out);
          if (m_have_prev) check("latency", m_gap, lat(m_prev_op) + m_stalls);
          inst = mem[m_pc];
          m_prev_op = inst[15:12]; m_have_prev = 1;
          m_gap = 0; m_stalls = 0; m_fetches++;
          exec(inst);
        end
      end
    end
    p_wait  = !reset && bus_req && !bus_ready;
    p_addr  = bus_addr; p_we = bus_we; p_wdata = bus_wdata;
    req_age = p_wait ? req_age + 1 : 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    tick(1); tick(1);
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (!m_halted && n < budget) begin tick(0); n++; end
    if (!m_halted) check("halt_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) tick(0);
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = 16'h6105; mem[1] = 16'h62FD; mem[2] = 16'h1312;
    mem[3] = 16'hA030; mem[4] = 16'hF000;
  endtask

  initial begin
    reset = 1'b1; bus_ready = 1'b0; ready_mode = 0;
    p_wait = 0; req_age = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset held 3 cycles in the middle of a stalled fetch
    load_basic();
    ready_mode = 1;
    do_reset();
    tick(0); tick(0);
    tick(1); tick(1); tick(1);
    tick(0);
    check("t1_first_req", bus_req, 1'b1);
    check("t1_first_addr", bus_addr, 16'h0000);
    check("t1_out", output_reg, 16'h0000);
    ready_mode = 0;
    run_to_halt(200);
    check("t1_final", output_reg, 16'h0002);

    // Basic program, zero wait states
    load_basic();
    ready_mode = 0;
    do_reset();
    run_to_halt(200);
    check("t2_out", output_reg, 16'h0002);
    check("t2_halted", halted, 1'b1);
    check("t2_fetches", m_fetches, 5);

    // Same program, 4 wait states per transfer
    load_basic();
    ready_mode = 1;
    do_reset();
    run_to_halt(300);
    check("t3_out", output_reg, 16'h0002);

    // Store then load back
    clear_mem();
    mem[0] = 16'h6120; mem[1] = 16'h627F; mem[2] = 16'h8012;
    mem[3] = 16'h7410; mem[4] = 16'hA040; mem[5] = 16'hF000;
    ready_mode = 0;
    do_reset();
    run_to_halt(200);
    check("t4_mem20", mem[16'h0020], 16'h007F);
    check("t4_out", output_reg, 16'h007F);

    // Countdown loop
    clear_mem();
    mem[0] = 16'h6103; mem[1] = 16'h6501; mem[2] = 16'h2115; mem[3] = 16'h9101;
    mem[4] = 16'h90FD; mem[5] = 16'hA010; mem[6] = 16'hF000;
    ready_mode = 2;
    do_reset();
    run_to_halt(400);
    check("t5_out", output_reg, 16'h0000);
    check("t5_fetches", m_fetches, 12);

    // Wraparound, r0 writes, illegal opcode, PC wrap through 0xFFFF
    clear_mem();
    mem[0] = 16'h61FF; mem[1] = 16'h6201; mem[2] = 16'h1312; mem[3] = 16'hA030;
    mem[4] = 16'h1011; mem[5] = 16'hA000; mem[6] = 16'hC000; mem[7] = 16'h90F7;
    mem[16'hFFFF] = 16'h9008;
    mem[8] = 16'h6742; mem[9] = 16'hA070; mem[10] = 16'hF000;
    ready_mode = 0;
    do_reset();
    run_to_halt(300);
    check("t6_out", output_reg, 16'h0042);
    check("t6_fetches", m_fetches, 12);

    // Random programs with random wait states and occasional resets
    for (int run = 0; run < 8; run++) begin
      for (int i = 0; i < 65536; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 19) != 0) w[15:12] = 4'h1;
        mem[i] = w;
      end
      ready_mode = 2;
      do_reset();
      for (int c = 0; c < 700 && !m_halted; c++) begin
        if ($urandom_range(0, 249) == 0) tick(1);
        else tick(0);
      end
      for (int i = 0; i < 3; i++) tick(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
